// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - control encodings, opcode/funct constants, state and class types
// Shared by the decoder, the FSM and the bench. No ports.
package mc_ctrl_pkg;

  localparam logic [1:0] EXTOP_ZERO = 2'b00;
  localparam logic [1:0] EXTOP_SIGN = 2'b01;
  localparam logic [1:0] EXTOP_HIGH = 2'b10;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_PASSB = 3'b101;

  localparam logic [1:0] NPCOP_PLUS4  = 2'b00;
  localparam logic [1:0] NPCOP_BRANCH = 2'b01;
  localparam logic [1:0] NPCOP_JUMP   = 2'b10;
  localparam logic [1:0] NPCOP_JR     = 2'b11;

  localparam logic [1:0] GPRSEL_RD  = 2'b00;
  localparam logic [1:0] GPRSEL_RT  = 2'b01;
  localparam logic [1:0] GPRSEL_R31 = 2'b10;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC  = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE_R = 4'd2,
    S_EXE_I = 4'd3,
    S_MA    = 4'd4,
    S_MR    = 4'd5,
    S_MW    = 4'd6,
    S_WB    = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_RALU, CLS_JR, CLS_J, CLS_JAL,
    CLS_IALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE
  } cls_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller <-> datapath signal bundle
// master: controller side (reads IR fields and Zero, drives strobes/selects/state).
// slave:  datapath side (the mirror image).
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       Zero;
  logic       PCWr;
  logic       IRWr;
  logic       MemWr;
  logic       RFWr;
  logic       BSel;
  logic [1:0] EXTOp;
  logic [2:0] ALUOp;
  logic [1:0] NPCOp;
  logic [1:0] GPRSel;
  logic [1:0] WDSel;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, Zero,
    output PCWr, IRWr, MemWr, RFWr, BSel, EXTOp, ALUOp, NPCOp,
           GPRSel, WDSel, illegal, state
  );

  modport slave (
    output opcode, funct, Zero,
    input  PCWr, IRWr, MemWr, RFWr, BSel, EXTOp, ALUOp, NPCOp,
           GPRSel, WDSel, illegal, state
  );
endinterface

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational opcode/funct decode
// in:  opcode[5:0], funct[5:0]
// out: cls (instruction class), alu_op (ALUOp for EXE_R/EXE_I), ext_op (EXTOp for EXE_I)
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [2:0] alu_op,
  output logic [1:0] ext_op
);

  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALUOP_ADD;
    ext_op = EXTOP_SIGN;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin cls = CLS_RALU; alu_op = ALUOP_ADD; end
          FN_SUBU: begin cls = CLS_RALU; alu_op = ALUOP_SUB; end
          FN_AND:  begin cls = CLS_RALU; alu_op = ALUOP_AND; end
          FN_OR:   begin cls = CLS_RALU; alu_op = ALUOP_OR;  end
          FN_SLT:  begin cls = CLS_RALU; alu_op = ALUOP_SLT; end
          FN_JR:   cls = CLS_JR;
          default: cls = CLS_ILL;
        endcase
      end
      OP_ADDIU: begin cls = CLS_IALU; alu_op = ALUOP_ADD;   ext_op = EXTOP_SIGN; end
      OP_ANDI:  begin cls = CLS_IALU; alu_op = ALUOP_AND;   ext_op = EXTOP_ZERO; end
      OP_ORI:   begin cls = CLS_IALU; alu_op = ALUOP_OR;    ext_op = EXTOP_ZERO; end
      OP_SLTI:  begin cls = CLS_IALU; alu_op = ALUOP_SLT;   ext_op = EXTOP_SIGN; end
      OP_LUI:   begin cls = CLS_IALU; alu_op = ALUOP_PASSB; ext_op = EXTOP_HIGH; end
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_BEQ:   cls = CLS_BEQ;
      OP_BNE:   cls = CLS_BNE;
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      default:  cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset main controller FSM
// in:  clk, rst_n (async, active low), bus.opcode/funct (IR fields), bus.Zero
// out: bus.PCWr/IRWr/MemWr/RFWr strobes, bus.BSel/EXTOp/ALUOp/NPCOp/GPRSel/WDSel
//      selects, bus.illegal (one-cycle pulse in DCD), bus.state (current state)
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  mc_ctrl_if.master bus
);

  state_t     state_q, state_d;
  cls_t       cls;
  logic [2:0] dec_alu;
  logic [1:0] dec_ext;

  logic       pcwr, irwr, memwr, rfwr, bsel, ill;
  logic [1:0] extop, npcop, gprsel, wdsel;
  logic [2:0] aluop;

  mc_ctrl_dec u_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls),
    .alu_op (dec_alu),
    .ext_op (dec_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    pcwr    = 1'b0;
    irwr    = 1'b0;
    memwr   = 1'b0;
    rfwr    = 1'b0;
    bsel    = 1'b0;
    ill     = 1'b0;
    extop   = EXTOP_SIGN;
    aluop   = ALUOP_ADD;
    npcop   = NPCOP_PLUS4;
    gprsel  = GPRSEL_RD;
    wdsel   = WDSEL_ALU;
    case (state_q)
      S_FETCH: begin
        irwr    = 1'b1;
        pcwr    = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        case (cls)
          CLS_RALU:                state_d = S_EXE_R;
          CLS_JR, CLS_J, CLS_JAL:  state_d = S_JMP;
          CLS_IALU:                state_d = S_EXE_I;
          CLS_LW, CLS_SW:          state_d = S_MA;
          CLS_BEQ, CLS_BNE:        state_d = S_BR;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXE_R: begin
        aluop   = dec_alu;
        state_d = S_WB;
      end
      S_EXE_I: begin
        bsel    = 1'b1;
        aluop   = dec_alu;
        extop   = dec_ext;
        state_d = S_WB;
      end
      S_MA: begin
        bsel    = 1'b1;
        state_d = (cls == CLS_SW) ? S_MW : S_MR;
      end
      S_MR: state_d = S_WB;
      S_MW: begin
        memwr   = 1'b1;
        state_d = S_FETCH;
      end
      S_WB: begin
        rfwr = 1'b1;
        if (cls == CLS_LW) begin
          gprsel = GPRSEL_RT;
          wdsel  = WDSEL_MEM;
        end else if (cls == CLS_IALU) begin
          gprsel = GPRSEL_RT;
        end
        state_d = S_FETCH;
      end
      S_BR: begin
        aluop   = ALUOP_SUB;
        npcop   = NPCOP_BRANCH;
        pcwr    = (cls == CLS_BNE) ? ~bus.Zero : bus.Zero;
        state_d = S_FETCH;
      end
      S_JMP: begin
        pcwr  = 1'b1;
        npcop = (cls == CLS_JR) ? NPCOP_JR : NPCOP_JUMP;
        if (cls == CLS_JAL) begin
          rfwr   = 1'b1;
          gprsel = GPRSEL_R31;
          wdsel  = WDSEL_PC;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // state already reads FETCH while reset is held; keep FETCH's strobes quiet.
    if (!rst_n) begin
      pcwr   = 1'b0;
      irwr   = 1'b0;
      memwr  = 1'b0;
      rfwr   = 1'b0;
      ill    = 1'b0;
      bsel   = 1'b0;
      extop  = 2'b00;
      aluop  = 3'b000;
      npcop  = 2'b00;
      gprsel = 2'b00;
      wdsel  = 2'b00;
    end
  end

  assign bus.PCWr    = pcwr;
  assign bus.IRWr    = irwr;
  assign bus.MemWr   = memwr;
  assign bus.RFWr    = rfwr;
  assign bus.BSel    = bsel;
  assign bus.EXTOp   = extop;
  assign bus.ALUOp   = aluop;
  assign bus.NPCOp   = npcop;
  assign bus.GPRSel  = gprsel;
  assign bus.WDSel   = wdsel;
  assign bus.illegal = ill;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct  = 6'b000000;
    bus.Zero   = 1'b0;
    #3;
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    checks++; if ({bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr, bus.illegal} !== 5'b0) begin failures++; $display("FAIL rst_enables got=%b exp=00000", {bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr, bus.illegal}); end
    checks++; if ({bus.BSel, bus.EXTOp, bus.ALUOp, bus.NPCOp, bus.GPRSel, bus.WDSel} !== 12'b0) begin failures++; $display("FAIL rst_selects got=%b exp=0", {bus.BSel, bus.EXTOp, bus.ALUOp, bus.NPCOp, bus.GPRSel, bus.WDSel}); end
    tick();
    tick();
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL rst_hold_state got=%0d exp=0", bus.state); end
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.IRWr, bus.PCWr} !== 2'b11) begin failures++; $display("FAIL rst_release_fetch got=%b exp=11", {bus.IRWr, bus.PCWr}); end
    checks++; if ({bus.NPCOp, bus.EXTOp} !== 4'b0001) begin failures++; $display("FAIL fetch_defaults got=%b exp=0001", {bus.NPCOp, bus.EXTOp}); end
  endtask

  task automatic test_lw();
    bus.opcode = 6'b100011;
    tick();
    checks++; if (bus.state !== 4'd1) begin failures++; $display("FAIL lw_dcd got=%0d exp=1", bus.state); end
    checks++; if ({bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr, bus.illegal} !== 5'b0) begin failures++; $display("FAIL lw_dcd_quiet got=%b exp=00000", {bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr, bus.illegal}); end
    tick();
    checks++; if (bus.state !== 4'd4) begin failures++; $display("FAIL lw_ma got=%0d exp=4", bus.state); end
    checks++; if ({bus.EXTOp, bus.BSel, bus.ALUOp} !== 6'b01_1_000) begin failures++; $display("FAIL lw_ma_ctl got=%b exp=011000", {bus.EXTOp, bus.BSel, bus.ALUOp}); end
    tick();
    checks++; if (bus.state !== 4'd5) begin failures++; $display("FAIL lw_mr got=%0d exp=5", bus.state); end
    checks++; if ({bus.PCWr, bus.MemWr, bus.RFWr} !== 3'b0) begin failures++; $display("FAIL lw_mr_quiet got=%b exp=000", {bus.PCWr, bus.MemWr, bus.RFWr}); end
    tick();
    checks++; if (bus.state !== 4'd7) begin failures++; $display("FAIL lw_wb got=%0d exp=7", bus.state); end
    checks++; if ({bus.RFWr, bus.MemWr, bus.GPRSel, bus.WDSel} !== 6'b1_0_01_01) begin failures++; $display("FAIL lw_wb_ctl got=%b exp=100101", {bus.RFWr, bus.MemWr, bus.GPRSel, bus.WDSel}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL lw_cpi5 got=%0d exp=0", bus.state); end
  endtask

  task automatic test_sw();
    bus.opcode = 6'b101011;
    tick();
    tick();
    checks++; if (bus.state !== 4'd4) begin failures++; $display("FAIL sw_ma got=%0d exp=4", bus.state); end
    tick();
    checks++; if (bus.state !== 4'd6) begin failures++; $display("FAIL sw_mw got=%0d exp=6", bus.state); end
    checks++; if ({bus.MemWr, bus.RFWr, bus.PCWr} !== 3'b100) begin failures++; $display("FAIL sw_mw_ctl got=%b exp=100", {bus.MemWr, bus.RFWr, bus.PCWr}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL sw_cpi4 got=%0d exp=0", bus.state); end
  endtask

  task automatic test_imm();
    logic [5:0] ops [4] = '{6'b001101, 6'b001001, 6'b001111, 6'b001100};
    logic [1:0] ext [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [2:0] alu [4] = '{3'b011, 3'b000, 3'b101, 3'b010};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = ops[i];
      tick();
      tick();
      checks++; if (bus.state !== 4'd3) begin failures++; $display("FAIL imm%0d_exe got=%0d exp=3", i, bus.state); end
      checks++; if ({bus.BSel, bus.EXTOp, bus.ALUOp} !== {1'b1, ext[i], alu[i]}) begin failures++; $display("FAIL imm%0d_ctl got=%b exp=%b", i, {bus.BSel, bus.EXTOp, bus.ALUOp}, {1'b1, ext[i], alu[i]}); end
      tick();
      checks++; if ({bus.state, bus.RFWr, bus.GPRSel, bus.WDSel} !== {4'd7, 1'b1, 2'b01, 2'b00}) begin failures++; $display("FAIL imm%0d_wb got=%b exp=011110100", i, {bus.state, bus.RFWr, bus.GPRSel, bus.WDSel}); end
      tick();
      checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL imm%0d_cpi4 got=%0d exp=0", i, bus.state); end
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [3] = '{6'b100011, 6'b101010, 6'b100101};
    logic [2:0] alu [3] = '{3'b001, 3'b100, 3'b011};
    bus.opcode = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      bus.funct = fns[i];
      tick();
      tick();
      checks++; if ({bus.state, bus.BSel, bus.ALUOp} !== {4'd2, 1'b0, alu[i]}) begin failures++; $display("FAIL r%0d_exe got=%b exp=%b", i, {bus.state, bus.BSel, bus.ALUOp}, {4'd2, 1'b0, alu[i]}); end
      tick();
      checks++; if ({bus.state, bus.RFWr, bus.GPRSel, bus.WDSel} !== {4'd7, 1'b1, 2'b00, 2'b00}) begin failures++; $display("FAIL r%0d_wb got=%b exp=011110000", i, {bus.state, bus.RFWr, bus.GPRSel, bus.WDSel}); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       zr  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = ops[i];
      bus.Zero   = zr[i];
      tick();
      tick();
      checks++; if ({bus.state, bus.NPCOp, bus.ALUOp, bus.BSel} !== {4'd8, 2'b01, 3'b001, 1'b0}) begin failures++; $display("FAIL br%0d_ctl got=%b exp=1000010010", i, {bus.state, bus.NPCOp, bus.ALUOp, bus.BSel}); end
      checks++; if (bus.PCWr !== pcw[i]) begin failures++; $display("FAIL br%0d_pcwr got=%b exp=%b", i, bus.PCWr, pcw[i]); end
      tick();
      checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL br%0d_cpi3 got=%0d exp=0", i, bus.state); end
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_jump();
    bus.opcode = 6'b000011;
    tick();
    tick();
    checks++; if ({bus.state, bus.PCWr, bus.NPCOp, bus.RFWr, bus.GPRSel, bus.WDSel} !== {4'd9, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10}) begin failures++; $display("FAIL jal_ctl got=%b exp=100111011010", {bus.state, bus.PCWr, bus.NPCOp, bus.RFWr, bus.GPRSel, bus.WDSel}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL jal_cpi3 got=%0d exp=0", bus.state); end
    bus.opcode = 6'b000000;
    bus.funct  = 6'b001000;
    tick();
    tick();
    checks++; if ({bus.state, bus.PCWr, bus.NPCOp, bus.RFWr} !== {4'd9, 1'b1, 2'b11, 1'b0}) begin failures++; $display("FAIL jr_ctl got=%b exp=10011110", {bus.state, bus.PCWr, bus.NPCOp, bus.RFWr}); end
    tick();
    bus.opcode = 6'b000010;
    tick();
    tick();
    checks++; if ({bus.state, bus.PCWr, bus.NPCOp, bus.RFWr} !== {4'd9, 1'b1, 2'b10, 1'b0}) begin failures++; $display("FAIL j_ctl got=%b exp=10011100", {bus.state, bus.PCWr, bus.NPCOp, bus.RFWr}); end
    tick();
    checks++; if (bus.state !== 4'd0) begin failures++; $display("FAIL j_cpi3 got=%0d exp=0", bus.state); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [2] = '{6'b111111, 6'b000000};
    bus.funct = 6'b000000;
    for (int i = 0; i < 2; i++) begin
      bus.opcode = ops[i];
      tick();
      checks++; if ({bus.state, bus.illegal} !== {4'd1, 1'b1}) begin failures++; $display("FAIL ill%0d_pulse got=%b exp=00011", i, {bus.state, bus.illegal}); end
      checks++; if ({bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr} !== 4'b0) begin failures++; $display("FAIL ill%0d_quiet got=%b exp=0000", i, {bus.PCWr, bus.IRWr, bus.MemWr, bus.RFWr}); end
      tick();
      checks++; if ({bus.state, bus.illegal} !== {4'd0, 1'b0}) begin failures++; $display("FAIL ill%0d_cpi2 got=%b exp=00000", i, {bus.state, bus.illegal}); end
    end
  endtask

  task automatic test_reset_mid();
    bus.opcode = 6'b100011;
    tick();
    tick();
    tick();
    checks++; if (bus.state !== 4'd5) begin failures++; $display("FAIL rmid_in_mr got=%0d exp=5", bus.state); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.state, bus.RFWr, bus.PCWr, bus.IRWr} !== 7'b0) begin failures++; $display("FAIL rmid_async got=%b exp=0000000", {bus.state, bus.RFWr, bus.PCWr, bus.IRWr}); end
    tick();
    checks++; if ({bus.state, bus.RFWr} !== 5'b0) begin failures++; $display("FAIL rmid_hold got=%b exp=00000", {bus.state, bus.RFWr}); end
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.state, bus.IRWr, bus.PCWr} !== {4'd0, 2'b11}) begin failures++; $display("FAIL rmid_release got=%b exp=000011", {bus.state, bus.IRWr, bus.PCWr}); end
    tick();
    checks++; if (bus.state !== 4'd1) begin failures++; $display("FAIL rmid_dcd got=%0d exp=1", bus.state); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_lw();
    test_sw();
    test_imm();
    test_rtype();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle MIPS-subset main controller FSM.
- Sits upstream of the immediate extender, ALU, register file, PC and memory.
- Decodes the held instruction's opcode/funct and sequences per-state control strobes, including EXTOp for the immediate extender.
- Moore-style: all strobes are a function of the current state and the instruction fields held in IR, plus Zero in the branch state.

Parameters:
- NONE: no parameters. Encodings are fixed constants, see Decomposition.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable after FETCH
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, combinational from the current ALU operation
- PCWr  out  1  PC write enable
- IRWr  out  1  instruction register write enable
- MemWr  out  1  data memory write enable
- RFWr  out  1  register file write enable
- BSel  out  1  ALU B source: 0 = register rt, 1 = Imm32
- EXTOp  out  2  immediate extend mode: ZERO 00, SIGN 01, HIGH 10
- ALUOp  out  3  ADD 000, SUB 001, AND 010, OR 011, SLT 100, PASSB 101
- NPCOp  out  2  PLUS4 00, BRANCH 01, JUMP 10, JR 11
- GPRSel  out  2  write register select: RD 00, RT 01, R31 10
- WDSel  out  2  write data select: ALU 00, MEM 01, PC 10
- illegal  out  1  one-cycle pulse in DCD when the opcode/funct is unsupported
- state  out  4  current state, for debug and verification

Behaviour:
- Reset: rst_n low forces state = FETCH immediately, asynchronously, including mid-instruction. While reset is held, all write enables (PCWr, IRWr, MemWr, RFWr) and illegal are forced 0. Mux selects are 0.
- Default every cycle: all enables 0, EXTOp SIGN, ALUOp ADD, NPCOp PLUS4, GPRSel RD, WDSel ALU, BSel 0.
- Supported instructions:
  - R-type (opcode 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
  - I-type: addiu 001001, andi 001100, ori 001101, lui 001111, slti 001010, lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: j 000010, jal 000011.
- States and transitions:
  - FETCH(0): IRWr = 1, PCWr = 1, NPCOp PLUS4. Next: DCD.
  - DCD(1): no writes. Next state by class:
    - R-ALU: EXE_R
    - jr, j, jal: JMP
    - addiu, andi, ori, lui, slti: EXE_I
    - lw, sw: MA
    - beq, bne: BR
    - anything else: illegal = 1, then FETCH.
  - EXE_R(2): BSel 0, ALUOp from funct. Next: WB.
  - EXE_I(3): BSel 1, with ALUOp and EXTOp per instruction:
    - addiu: ADD, SIGN
    - andi: AND, ZERO
    - ori: OR, ZERO
    - slti: SLT, SIGN
    - lui: PASSB, HIGH
    - Next: WB.
  - MA(4): BSel 1, EXTOp SIGN, ALUOp ADD. Next: MR for lw, MW for sw.
  - MR(5): memory read cycle, no writes. Next: WB.
  - MW(6): MemWr = 1. Next: FETCH.
  - WB(7): RFWr = 1; GPRSel/WDSel by instruction:
    - R-type: RD / ALU
    - I-ALU: RT / ALU
    - lw: RT / MEM
    - Next: FETCH.
  - BR(8): ALUOp SUB, BSel 0, EXTOp SIGN, NPCOp BRANCH. PCWr = Zero for beq, PCWr = ~Zero for bne. Next: FETCH.
  - JMP(9): NPCOp JUMP for j/jal, JR for jr; PCWr = 1. jal additionally: RFWr = 1, GPRSel R31, WDSel PC (PC already holds PC+4). Next: FETCH.
  - Unused state codes 10–15: go to FETCH, no writes.
- Cycles per instruction:
  - branch, j, jal, jr: 3
  - R-ALU, I-ALU, sw: 4
  - lw: 5
  - illegal: 2
- Exactly one PCWr pulse per FETCH. MemWr and RFWr are never asserted in the same cycle.

Decomposition:
- Shared control-definition include holds:
  - EXTOP_*, ALUOP_*, NPCOP_*, GPRSEL_*, WDSEL_* constants
  - opcode and funct constants
  - state encodings
- Sub-module mc_ctrl_dec: purely combinational opcode/funct to instruction-class and per-instruction ALUOp/EXTOp decode. The FSM uses its outputs.

Test Plan:
- Reset mid-op: assert rst_n = 0 during MR of a lw → state = 0 immediately, RFWr never pulses. Release → next edge IRWr = PCWr = 1.
- lw (opcode 100011): states 0,1,4,5,7. MA has EXTOp 01, BSel 1. WB has RFWr 1, GPRSel 01, WDSel 01. Total 5 cycles.
- Immediates:
  - ori → EXTOp 00, ALUOp 011
  - addiu → EXTOp 01, ALUOp 000
  - lui → EXTOp 10, ALUOp 101
  - each in EXE_I, then WB with GPRSel 01.
- beq with Zero = 1 → PCWr 1, NPCOp 01 in state 8. beq with Zero = 0 → PCWr 0. bne with Zero = 0 → PCWr 1. Each takes 3 cycles.
- jal: state 9 asserts PCWr 1, NPCOp 10, RFWr 1, GPRSel 10, WDSel 10. jr (funct 001000): NPCOp 11, RFWr 0.
- Illegal opcode 111111, or R-type funct 000000: illegal pulses 1 for one cycle in DCD, no write enables asserted, back to FETCH after 2 cycles.
